// File: rtl/four_to_one_mux_arbiter_if.sv
// Bundle of the four input channels and the single output stream of the 4:1 arbiter.
interface four_to_one_mux_arbiter_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in0, in1, in2, in3, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );

  modport slave (
    input  in0, in1, in2, in3, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/four_to_one_mux_arbiter.sv
// Round-robin 4:1 stream merger with packet locking and a single registered output slot.
// Optional output beat counter enabled by defining MUX_BEAT_COUNT_EN.
//
// state | meaning
// ARB   | round-robin search starting after last_grant
// LOCK  | mid-packet, only lock_ch may transfer until its in_last beat
module four_to_one_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  four_to_one_mux_arbiter_if.slave  bus
`ifdef MUX_BEAT_COUNT_EN
  ,
  output logic [15:0]               beat_count
`endif
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state, next_state;
  logic [1:0]       last_grant, last_grant_nxt;
  logic [1:0]       lock_ch, lock_ch_nxt;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_hit;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    grant_hit      = 1'b0;
    grant_idx      = 2'd0;
    cand           = 2'd0;
    next_state     = state;
    last_grant_nxt = last_grant;
    lock_ch_nxt    = lock_ch;
    sel_data       = '0;

    if (state == LOCK) begin
      grant_hit = bus.in_valid[lock_ch];
      grant_idx = lock_ch;
    end else begin
      // first valid channel after last_grant, wrapping naturally in 2 bits
      for (int unsigned i = 1; i <= 4; i++) begin
        cand = last_grant + 2'(i);
        if (!grant_hit && bus.in_valid[cand]) begin
          grant_hit = 1'b1;
          grant_idx = cand;
        end
      end
    end

    free         = !bus.out_valid || bus.out_ready;
    xfer         = grant_hit && free;
    bus.in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    if (xfer) begin
      if (bus.in_last[grant_idx]) begin
        next_state     = ARB;
        last_grant_nxt = grant_idx;
      end else begin
        next_state  = LOCK;
        lock_ch_nxt = grant_idx;
      end
    end

    case (grant_idx)
      2'd0:    sel_data = bus.in0;
      2'd1:    sel_data = bus.in1;
      2'd2:    sel_data = bus.in2;
      default: sel_data = bus.in3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= 2'd3;
      lock_ch    <= 2'd0;
    end else begin
      state      <= next_state;
      last_grant <= last_grant_nxt;
      lock_ch    <= lock_ch_nxt;
    end
  end

  // A fill replaces the slot even while it drains; only the valid flag clears on a bare drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= 2'd0;
      bus.out_last  <= 1'b0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_sel   <= grant_idx;
      bus.out_last  <= bus.in_last[grant_idx];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUX_BEAT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= 16'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_four_to_one_mux_arbiter.sv
// Bench for four_to_one_mux_arbiter: behavioural model compared every cycle plus directed cases.
module tb_four_to_one_mux_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  four_to_one_mux_arbiter_if #(.WIDTH(8)) bus ();

`ifdef MUX_BEAT_COUNT_EN
  logic [15:0] beat_count;
  four_to_one_mux_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .beat_count(beat_count));
`else
  four_to_one_mux_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  // model: packet lock, round-robin pointer, one output slot
  logic        m_locked = 1'b0;
  int          m_lock_ch = 0;
  int          m_last = 3;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data = 8'd0;
  logic [1:0]  m_sel = 2'd0;
  logic        m_olast = 1'b0;
  logic [15:0] m_count = 16'd0;
  int          m_xfers = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (m_locked) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int i = 1; i <= 4; i++) begin
      if (bus.in_valid[(m_last + i) % 4]) return (m_last + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    if (g >= 0 && (!m_valid || bus.out_ready)) return 4'(1 << g);
    return 4'd0;
  endfunction

  function automatic logic [7:0] data_of(input int k);
    case (k)
      0:       return bus.in0;
      1:       return bus.in1;
      2:       return bus.in2;
      default: return bus.in3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_locked <= 1'b0; m_lock_ch <= 0; m_last <= 3;
      m_valid <= 1'b0; m_data <= 8'd0; m_sel <= 2'd0; m_olast <= 1'b0;
      m_count <= 16'd0; m_xfers <= 0;
    end else begin
      if (m_valid && bus.out_ready) begin
        m_count <= m_count + 16'd1;
        m_xfers <= m_xfers + 1;
      end
      if (exp_ready() != 4'd0) begin
        m_valid <= 1'b1;
        m_data  <= data_of(exp_grant());
        m_sel   <= 2'(exp_grant());
        m_olast <= bus.in_last[exp_grant()];
        if (bus.in_last[exp_grant()]) begin
          m_locked <= 1'b0;
          m_last   <= exp_grant();
        end else begin
          m_locked  <= 1'b1;
          m_lock_ch <= exp_grant();
        end
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",  32'(bus.in_ready),  32'(exp_ready()));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data",  32'(bus.out_data),  32'(m_data));
    check("out_sel",   32'(bus.out_sel),   32'(m_sel));
    check("out_last",  32'(bus.out_last),  32'(m_olast));
`ifdef MUX_BEAT_COUNT_EN
    check("beat_count", 32'(beat_count), 32'(m_count));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l);
    bus.in_valid = v;
    bus.in_last  = l;
  endtask

  initial begin
    bus.in0 = 8'h10; bus.in1 = 8'h11; bus.in2 = 8'h12; bus.in3 = 8'h13;
    drive(4'b0000, 4'b0000);
    bus.out_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_sel",   32'(bus.out_sel),   32'd0);
    check("rst_last",  32'(bus.out_last),  32'd0);
    reset = 1'b0;

    // round robin over all four channels
    drive(4'b1111, 4'b1111);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
      step();
      check("rr_sel", 32'(bus.out_sel), 32'(k % 4));
      check("rr_data", 32'(bus.out_data), 32'(8'h10 + (k % 4)));
    end
    drive(4'b0000, 4'b0000);
    step();

    // 3-beat packet on ch2 while ch1 waits
    drive(4'b0100, 4'b0000); bus.in2 = 8'h21;
    @(negedge clk); check("lk_ready0", 32'(bus.in_ready), 32'h4);
    step(); check("lk_sel0", 32'(bus.out_sel), 32'd2);
    drive(4'b0110, 4'b0010); bus.in2 = 8'h22;
    @(negedge clk); check("lk_ready1", 32'(bus.in_ready), 32'h4);
    step(); check("lk_sel1", 32'(bus.out_sel), 32'd2);
    drive(4'b0110, 4'b0110); bus.in2 = 8'h23;
    @(negedge clk); check("lk_ready2", 32'(bus.in_ready), 32'h4);
    step(); check("lk_sel2", 32'(bus.out_sel), 32'd2);
    check("lk_last2", 32'(bus.out_last), 32'd1);
    @(negedge clk); check("lk_ready3", 32'(bus.in_ready), 32'h2);
    step(); check("lk_sel3", 32'(bus.out_sel), 32'd1);
    drive(4'b0000, 4'b0000);
    step();

    // backpressure holds the slot
    bus.out_ready = 1'b0;
    bus.in0 = 8'hA5;
    drive(4'b0001, 4'b0001);
    step();
    bus.in0 = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("st_ready", 32'(bus.in_ready), 32'd0);
      check("st_data", 32'(bus.out_data), 32'hA5);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk); check("st_rel_ready", 32'(bus.in_ready), 32'h1);
    step(); check("st_rel_data", 32'(bus.out_data), 32'h5A);
    drive(4'b0000, 4'b0000);
    step();

    // lone ch3 streams without bubbles
    drive(4'b1000, 4'b1000);
    for (int k = 0; k < 6; k++) begin
      bus.in3 = 8'(8'h30 + k);
      @(negedge clk); check("c3_ready", 32'(bus.in_ready), 32'h8);
      step();
      check("c3_valid", 32'(bus.out_valid), 32'd1);
      check("c3_data", 32'(bus.out_data), 32'(8'h30 + k));
    end
    drive(4'b1111, 4'b1111);
    @(negedge clk); check("c3_next", 32'(bus.in_ready), 32'h1);
    step();
    drive(4'b0000, 4'b0000);
    step();

    // reset while locked on ch1
    drive(4'b0010, 4'b0000);
    step();
    check("rl_valid_pre", 32'(bus.out_valid), 32'd1);
    #1 reset = 1'b1;
    #1 check("rl_valid", 32'(bus.out_valid), 32'd0);
    step();
    reset = 1'b0;
    drive(4'b1111, 4'b1111);
    @(negedge clk); check("rl_grant", 32'(bus.in_ready), 32'h1);
    step();
    drive(4'b0000, 4'b0000);
    step();

    // randomized traffic, checked by the per-cycle compare
    for (int k = 0; k < 2000; k++) begin
      bus.in0 = 8'($urandom); bus.in1 = 8'($urandom);
      bus.in2 = 8'($urandom); bus.in3 = 8'($urandom);
      drive(4'($urandom), 4'($urandom | $urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef MUX_BEAT_COUNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(4'b0001, 4'b0001);
    bus.out_ready = 1'b1;
    begin
      int budget = 70000;
      while (m_xfers < 65537 && budget > 0) begin
        step();
        budget--;
      end
      check("bc_budget", 32'(m_xfers), 32'd65537);
      check("bc_wrap", 32'(beat_count), 32'd1);
    end
    drive(4'b0000, 4'b0000);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
